// File: rtl/pulse_gen.sv
// Long/short pulse/space line-code transmitter: a DEPTH-entry symbol FIFO feeds a run-length engine driving `out`.
// Optional macro PULSE_GEN_IDLE_RTZ_EN forces out low when the engine drops back to idle.
module pulse_gen #(
    parameter int SHORT_LEN = 1,
    parameter int LONG_LEN  = 2,
    parameter int CW        = 4,
    parameter int DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sym_valid,
    input  logic [1:0] sym,
    output logic       sym_ready,
    output logic       out,
    output logic       busy,
    output logic       merge,
    output logic       underrun
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE    = 1;
    localparam logic [CW-1:0] CNT_ONE    = 1;
    localparam logic [CW-1:0] SHORT_LOAD = CW'(SHORT_LEN - 1);
    localparam logic [CW-1:0] LONG_LOAD  = CW'(LONG_LEN - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    logic [1:0]    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]   wr_ptr_d, rd_ptr_d;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          out_q, busy_q, merge_q, underrun_q;

    logic          full, empty, push, pop, cnt_zero;
    logic [1:0]    head;
    logic [CW-1:0] load_d;

    // The extra pointer MSB distinguishes a full FIFO from an empty one.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign cnt_zero = (cnt_q == '0);
    assign load_d   = head[1] ? LONG_LOAD : SHORT_LOAD;

    assign sym_ready = ~full;
    assign push      = sym_valid & ~full;
    assign pop       = ~empty & ((state_q == IDLE) | cnt_zero);
    assign wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d  = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= sym;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            out_q      <= 1'b0;
            busy_q     <= 1'b0;
            merge_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            merge_q    <= 1'b0;
            underrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q <= PLAY;
                        out_q   <= head[0];
                        cnt_q   <= load_d;
                        busy_q  <= 1'b1;
                    end
                end
                PLAY: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (!empty) begin
                        // Back-to-back load; equal levels fuse into one run on the line.
                        out_q   <= head[0];
                        cnt_q   <= load_d;
                        merge_q <= (head[0] == out_q);
                    end else begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        underrun_q <= 1'b1;
`ifdef PULSE_GEN_IDLE_RTZ_EN
                        out_q      <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out      = out_q;
    assign busy     = busy_q;
    assign merge    = merge_q;
    assign underrun = underrun_q;
endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen, checked every cycle against a symbol-queue/run-length model.
module tb_pulse_gen;
    localparam int SHORT_LEN = 1;
    localparam int LONG_LEN  = 2;
    localparam int DEPTH     = 4;
`ifdef PULSE_GEN_IDLE_RTZ_EN
    localparam logic IDLE_LVL_AFTER_HIGH = 1'b0;
`else
    localparam logic IDLE_LVL_AFTER_HIGH = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sym_valid = 1'b0;
    logic [1:0] sym = 2'b00;
    logic       sym_ready, out, busy, merge, underrun;

    int vectors = 0;
    int miscompares = 0;

    pulse_gen #(.SHORT_LEN(SHORT_LEN), .LONG_LEN(LONG_LEN), .CW(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym(sym),
        .sym_ready(sym_ready), .out(out), .busy(busy), .merge(merge), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Model: queued symbols plus cycles remaining in the symbol on the line.
    logic [1:0] mq[$];
    int         m_rem;
    logic       m_out, m_busy, m_merge, m_underrun;
    logic [3:0] trace[$];

    task automatic model_reset();
        mq.delete();
        m_rem = 0; m_out = 0; m_busy = 0; m_merge = 0; m_underrun = 0;
    endtask

    task automatic model_edge(input logic v, input logic [1:0] s);
        logic       room;
        logic [1:0] hd;
        room = (mq.size() < DEPTH);
        m_merge = 0;
        m_underrun = 0;
        if (m_rem > 1) begin
            m_rem--;
        end else if (mq.size() > 0) begin
            hd = mq.pop_front();
            if (m_busy && hd[0] == m_out) m_merge = 1;
            m_out  = hd[0];
            m_rem  = hd[1] ? LONG_LEN : SHORT_LEN;
            m_busy = 1;
        end else if (m_busy) begin
            m_busy = 0;
            m_underrun = 1;
            m_rem = 0;
`ifdef PULSE_GEN_IDLE_RTZ_EN
            m_out = 0;
`endif
        end
        if (v && room) mq.push_back(s);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("out", out, m_out);
        chk("busy", busy, m_busy);
        chk("merge", merge, m_merge);
        chk("underrun", underrun, m_underrun);
        chk("sym_ready", sym_ready, mq.size() < DEPTH);
    endtask

    task automatic step(input logic v, input logic [1:0] s);
        sym_valid = v;
        sym = s;
        @(posedge clk);
        model_edge(v, s);
        @(negedge clk);
        cmp_all();
        trace.push_back({underrun, merge, busy, out});
        sym_valid = 0;
    endtask

    function automatic int count_bit(input int b);
        int n = 0;
        foreach (trace[i]) if (trace[i][b]) n++;
        return n;
    endfunction

    initial begin
        logic [1:0] syms[4];
        logic       accepted;
        int         stalls, guard;

        // Reset held low for 2 cycles, then idle.
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_ready", sym_ready, 1);
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        trace.delete();
        repeat (5) step(0, 2'b00);
        chk("idle_flags", count_bit(3) + count_bit(2) + count_bit(1), 0);

        // Single short pulse then underrun.
        trace.delete();
        step(1, 2'b01);
        repeat (3) step(0, 2'b00);
        chk("short_e0", trace[0], 4'b0000);
        chk("short_e1", trace[1], 4'b0011);
        chk("short_e2", trace[2], {3'b100, IDLE_LVL_AFTER_HIGH});
        chk("short_e3", trace[3], {3'b000, IDLE_LVL_AFTER_HIGH});

        // Back-to-back 11,00,11,10: line reads 1,1,0,1,1,0,0.
        trace.delete();
        syms = '{2'b11, 2'b00, 2'b11, 2'b10};
        foreach (syms[i]) step(1, syms[i]);
        repeat (6) step(0, 2'b00);
        begin
            logic [6:0] lvl, exp_lvl;
            exp_lvl = 7'b1101100;
            for (int i = 0; i < 7; i++) begin
                lvl[6-i] = trace[i+1][0];
                chk("b2b_busy", trace[i+1][1], 1);
            end
            chk("b2b_levels", lvl, exp_lvl);
        end
        chk("b2b_merge", count_bit(2), 0);
        chk("b2b_underrun_n", count_bit(3), 1);
        chk("b2b_underrun_at", trace[8][3], 1);

        // 01 then 11 fuse into a 3-cycle high run with one merge.
        trace.delete();
        step(1, 2'b01);
        step(1, 2'b11);
        repeat (4) step(0, 2'b00);
        chk("merge_run", {trace[1][0], trace[2][0], trace[3][0]}, 3'b111);
        chk("merge_at", trace[2][2], 1);
        chk("merge_n", count_bit(2), 1);
        chk("merge_underrun_at", trace[4][3], 1);

        // Eight long symbols of alternating level: FIFO fills, one refused cycle.
        trace.delete();
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            guard = 0;
            do begin
                accepted = (mq.size() < DEPTH);
                if (!accepted) stalls++;
                step(1, {1'b1, k[0]});
                guard++;
            end while (!accepted && guard < 20);
            if (!accepted) chk("fill_timeout", 0, 1);
        end
        repeat (20) step(0, 2'b00);
        chk("fill_stalls", stalls, 1);
        chk("fill_merge", count_bit(2), 0);
        chk("fill_underrun", count_bit(3), 1);
        chk("fill_drained", mq.size(), 0);

        // Asynchronous reset in the middle of a long pulse with 3 symbols queued.
        trace.delete();
        syms = '{2'b10, 2'b11, 2'b00, 2'b01};
        foreach (syms[i]) step(1, syms[i]);
        step(1, 2'b10);
        chk("pre_rst_out", out, 1);
        chk("pre_rst_queued", mq.size(), 3);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk("arst_out", out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_flags", {merge, underrun}, 0);
        @(negedge clk);
        rst_n = 1;
        trace.delete();
        repeat (5) step(0, 2'b00);
        chk("post_rst_busy", count_bit(1), 0);
        chk("post_rst_out", count_bit(0), 0);
        step(1, 2'b11);
        repeat (4) step(0, 2'b00);
        chk("post_rst_play", {trace[6][0], trace[7][0]}, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
